// File: rtl/pe_acc_buffer_pkg.sv
// Shared definitions for the PE output accumulation buffer.
//   Array geometry, word/address widths and the drain FSM state encoding.
package pe_pkg;
   localparam int ARRAY_DIM = 16;
   localparam int ACC_W     = 32;
   localparam int OUT_W     = 8;
   localparam int DEPTH     = 1024;
   localparam int ADDR_W    = 10;
   localparam int CNT_W     = ADDR_W + 1;
   localparam int ACC_BUS_W = ARRAY_DIM * ACC_W;
   localparam int OUT_BUS_W = ARRAY_DIM * OUT_W;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_EMPTY = 2'd1,
      ST_DRAIN      = 2'd2,
      ST_DONE       = 2'd3
   } drain_state_t;
endpackage

// File: rtl/pe_acc_buffer_if.sv
// Readout stream from the accumulation buffer toward output memory.
//   out_valid/out_ready : valid/ready handshake
//   out_data            : requantised lanes, lane i = bits [i*OUT_W +: OUT_W]
//   out_addr            : buffer address the beat was read from
interface pe_acc_buffer_if;
   import pe_pkg::*;

   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_BUS_W-1:0] out_data;
   logic [ADDR_W-1:0]    out_addr;

   modport master (output out_valid, output out_data, output out_addr, input out_ready);
   modport slave  (input out_valid, input out_data, input out_addr, output out_ready);
endinterface

// File: rtl/pe_requant_lane.sv
// One lane of the drain requantiser (combinational).
//   i_v       : signed partial sum
//   i_shift   : arithmetic right shift with round-half-up
//   i_relu_en : clamp negatives to zero first
//   o_q       : result saturated to the signed OUT_W range
module pe_requant_lane
   import pe_pkg::*;
(
   input  logic [ACC_W-1:0] i_v,
   input  logic [4:0]       i_shift,
   input  logic             i_relu_en,
   output logic [OUT_W-1:0] o_q
);
   localparam logic signed [ACC_W:0] ONE   = 1;
   localparam logic signed [ACC_W:0] Q_MAX = (2 ** (OUT_W - 1)) - 1;
   localparam logic signed [ACC_W:0] Q_MIN = -(2 ** (OUT_W - 1));

   logic signed [ACC_W:0] w_r;
   logic signed [ACC_W:0] w_half;
   logic signed [ACC_W:0] w_rnd;
   logic signed [ACC_W:0] w_sh;

   // One guard bit keeps the rounding add from overflowing at +max.
   // (1 << shift) >> 1 yields the half-LSB, and zero when shift is 0.
   always_comb begin
      w_r    = (i_relu_en && i_v[ACC_W-1]) ? '0 : {i_v[ACC_W-1], i_v};
      w_half = (ONE <<< i_shift) >>> 1;
      w_rnd  = w_r + w_half;
      w_sh   = w_rnd >>> i_shift;
      if (w_sh > Q_MAX)
         o_q = Q_MAX[OUT_W-1:0];
      else if (w_sh < Q_MIN)
         o_q = Q_MIN[OUT_W-1:0];
      else
         o_q = w_sh[OUT_W-1:0];
   end
endmodule

// File: rtl/pe_acc_buffer.sv
// Output accumulation buffer behind the PE array.
//   clk, rst_n          : clock, synchronous active-low reset
//   acc_enable/clear/addr, pe_acc_in : read-modify-write accumulate requests
//   drain_start/count, shift, relu_en : readout command and requant setup
//   ob                  : requantised readout stream (master)
//   busy, drain_done, err_overlap     : status
//
// state         | meaning
// ST_IDLE       | accumulating, accepts drain_start
// ST_WAIT_EMPTY | let the RMW pipeline retire before reading
// ST_DRAIN      | reading words 0..count-1 out through the requantiser
// ST_DONE       | last beat accepted, drain_done high for this cycle
module pe_acc_buffer
   import pe_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 acc_enable,
   input  logic                 acc_clear,
   input  logic [ADDR_W-1:0]    acc_addr,
   input  logic [ACC_BUS_W-1:0] pe_acc_in,
   input  logic                 drain_start,
   input  logic [CNT_W-1:0]     drain_count,
   input  logic [4:0]           shift,
   input  logic                 relu_en,
   pe_acc_buffer_if.master      ob,
   output logic                 busy,
   output logic                 drain_done,
   output logic                 err_overlap
);
   logic [ACC_BUS_W-1:0] r_mem [DEPTH];

   logic                 r_s1_vld;
   logic                 r_s1_clr;
   logic [ADDR_W-1:0]    r_s1_addr;
   logic [ACC_BUS_W-1:0] r_s1_in;
   logic [ACC_BUS_W-1:0] r_rd_data;
   logic [ACC_BUS_W-1:0] w_sum;

   drain_state_t         r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     r_iss_cnt;
   logic [CNT_W-1:0]     r_beat_cnt;
   logic [4:0]           r_shift;
   logic                 r_relu;
   logic                 r_dr_vld;
   logic [ADDR_W-1:0]    r_dr_addr;
   logic [ACC_BUS_W-1:0] r_dr_raw;
   logic [OUT_BUS_W-1:0] w_dr_q;
   logic                 r_sk_vld;
   logic [OUT_BUS_W-1:0] r_sk_data;
   logic [ADDR_W-1:0]    r_sk_addr;
   logic                 r_out_vld;
   logic [OUT_BUS_W-1:0] r_out_data;
   logic [ADDR_W-1:0]    r_out_addr;
   logic                 r_done;
   logic                 r_err;

   logic                 w_acc;
   logic [1:0]           w_occ;
   logic                 w_issue;
   logic [ADDR_W-1:0]    w_iss_addr;

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < ARRAY_DIM; i++)
         w_sum[i*ACC_W +: ACC_W] = r_s1_clr ? r_s1_in[i*ACC_W +: ACC_W]
                                            : r_rd_data[i*ACC_W +: ACC_W] + r_s1_in[i*ACC_W +: ACC_W];
   end

   // Slots that stay occupied after this edge (output + skid + read landing).
   // A new read may only be issued if one slot will still be free for it.
   // Reads also wait while an RMW write is pending so they never see stale data.
   assign w_acc      = r_out_vld && ob.out_ready;
   assign w_occ      = {1'b0, r_out_vld} + {1'b0, r_sk_vld} + {1'b0, r_dr_vld} - {1'b0, w_acc};
   assign w_iss_addr = r_iss_cnt[ADDR_W-1:0];
   assign w_issue    = (r_state == ST_DRAIN) && (r_iss_cnt < r_cnt) && (w_occ < 2'd2) && !r_s1_vld;

   always_ff @(posedge clk) begin
      if (r_s1_vld)
         r_mem[r_s1_addr] <= w_sum;
      // Forward the sum being written this edge to a back-to-back hit.
      if (r_s1_vld && (r_s1_addr == acc_addr))
         r_rd_data <= w_sum;
      else
         r_rd_data <= r_mem[acc_addr];
      r_s1_clr  <= acc_clear;
      r_s1_addr <= acc_addr;
      r_s1_in   <= pe_acc_in;
      if (w_issue) begin
         r_dr_raw  <= r_mem[w_iss_addr];
         r_dr_addr <= w_iss_addr;
      end
      if (r_dr_vld && r_out_vld && !w_acc)
         {r_sk_data, r_sk_addr} <= {w_dr_q, r_dr_addr};
      else if (r_dr_vld && r_sk_vld)
         {r_sk_data, r_sk_addr} <= {w_dr_q, r_dr_addr};
   end

   for (genvar g = 0; g < ARRAY_DIM; g++) begin : g_lane
      pe_requant_lane u_lane (
         .i_v       (r_dr_raw[g*ACC_W +: ACC_W]),
         .i_shift   (r_shift),
         .i_relu_en (r_relu),
         .o_q       (w_dr_q[g*OUT_W +: OUT_W])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_s1_vld   <= 1'b0;
         r_dr_vld   <= 1'b0;
         r_sk_vld   <= 1'b0;
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
         r_out_addr <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
         r_iss_cnt  <= '0;
         r_beat_cnt <= '0;
         r_shift    <= '0;
         r_relu     <= 1'b0;
      end else begin
         r_s1_vld <= acc_enable;
         r_dr_vld <= w_issue;
         r_done   <= 1'b0;
         if (acc_enable && (r_state == ST_DRAIN))
            r_err <= 1'b1;
         if (w_issue)
            r_iss_cnt <= r_iss_cnt + CNT_W'(1);

         // Skid drains into the output first so beats stay in address order.
         if (!r_out_vld || w_acc) begin
            if (r_sk_vld) begin
               r_out_vld  <= 1'b1;
               r_out_data <= r_sk_data;
               r_out_addr <= r_sk_addr;
               r_sk_vld   <= r_dr_vld;
            end else if (r_dr_vld) begin
               r_out_vld  <= 1'b1;
               r_out_data <= w_dr_q;
               r_out_addr <= r_dr_addr;
            end else begin
               r_out_vld  <= 1'b0;
            end
         end else if (r_dr_vld) begin
            r_sk_vld <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (drain_start) begin
                  if (drain_count == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state    <= ST_WAIT_EMPTY;
                     r_cnt      <= drain_count;
                     r_shift    <= shift;
                     r_relu     <= relu_en;
                     r_iss_cnt  <= '0;
                     r_beat_cnt <= '0;
                  end
               end
            end
            ST_WAIT_EMPTY: begin
               if (!r_s1_vld)
                  r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_acc) begin
                  if (r_beat_cnt == r_cnt - CNT_W'(1)) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ob.out_valid = r_out_vld;
   assign ob.out_data  = r_out_data;
   assign ob.out_addr  = r_out_addr;
   assign busy         = r_s1_vld || (r_state != ST_IDLE);
   assign drain_done   = r_done;
   assign err_overlap  = r_err;
endmodule

// File: tb/tb_pe_acc_buffer.sv
// Directed self-checking bench for pe_acc_buffer.
module tb_pe_acc_buffer;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         acc_enable;
   logic         acc_clear;
   logic [9:0]   acc_addr;
   logic [511:0] pe_acc_in;
   logic         drain_start;
   logic [10:0]  drain_count;
   logic [4:0]   shift;
   logic         relu_en;
   logic         busy;
   logic         drain_done;
   logic         err_overlap;

   pe_acc_buffer_if ob();

   pe_acc_buffer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .acc_enable  (acc_enable),
      .acc_clear   (acc_clear),
      .acc_addr    (acc_addr),
      .pe_acc_in   (pe_acc_in),
      .drain_start (drain_start),
      .drain_count (drain_count),
      .shift       (shift),
      .relu_en     (relu_en),
      .ob          (ob.master),
      .busy        (busy),
      .drain_done  (drain_done),
      .err_overlap (err_overlap)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [9:0]   b_addr[$];
   logic [127:0] b_data[$];
   bit           rdy_pat[$];
   int           done_cnt;
   int           unstable_cnt;
   int           first_lat;
   int           beats_at_done;

   function automatic logic [511:0] lane_vec(input int lane, input logic [31:0] v);
      logic [511:0] t;
      t = '0;
      t[lane*32 +: 32] = v;
      return t;
   endfunction

   task automatic acc_drive(input logic [9:0] a, input logic [511:0] d, input bit clr);
      @(negedge clk);
      acc_enable = 1'b1;
      acc_clear  = clr;
      acc_addr   = a;
      pe_acc_in  = d;
   endtask

   task automatic acc_idle();
      @(negedge clk);
      acc_enable = 1'b0;
      acc_clear  = 1'b0;
   endtask

   // Starts a drain and gathers beats, applying rdy_pat from the first valid cycle.
   task automatic run_drain(input int cnt, input int sh, input bit relu, input int budget);
      bit           seen, stalled, rdy;
      logic [127:0] st_data;
      logic [9:0]   st_addr;
      int           pidx, done_cyc;
      b_addr.delete();
      b_data.delete();
      done_cnt = 0; unstable_cnt = 0; first_lat = -1; beats_at_done = -1;
      seen = 0; stalled = 0; pidx = 0; done_cyc = -1;
      st_data = '0; st_addr = '0;
      @(negedge clk);
      drain_start = 1'b1;
      drain_count = cnt[10:0];
      shift       = sh[4:0];
      relu_en     = relu;
      ob.out_ready = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         drain_start = 1'b0;
         if (drain_done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = k;
               beats_at_done = b_addr.size();
            end
         end
         if (stalled && (!ob.out_valid || ob.out_data !== st_data || ob.out_addr !== st_addr))
            unstable_cnt++;
         if (ob.out_valid && !seen) begin
            seen = 1;
            first_lat = k;
         end
         rdy = 1'b1;
         if (seen) begin
            if (pidx < rdy_pat.size()) rdy = rdy_pat[pidx];
            pidx++;
         end
         ob.out_ready = rdy;
         if (ob.out_valid && rdy) begin
            b_addr.push_back(ob.out_addr);
            b_data.push_back(ob.out_data);
         end
         stalled = ob.out_valid && !rdy;
         st_data = ob.out_data;
         st_addr = ob.out_addr;
         if (done_cyc >= 0 && k >= done_cyc + 4) break;
      end
      ob.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (ob.out_valid !== 1'b0 || busy !== 1'b0 || drain_done !== 1'b0 || err_overlap !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_flags: valid=%b busy=%b done=%b err=%b, required all 0",
                  ob.out_valid, busy, drain_done, err_overlap);
      end
      n_checks++;
      if (ob.out_data !== 128'd0 || ob.out_addr !== 10'd0) begin
         n_errors++;
         $display("FAIL reset_data: data=%h addr=%0d, required 0/0", ob.out_data, ob.out_addr);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_clear_accumulate();
      acc_drive(10'd5, lane_vec(0, 32'd10), 1'b1);
      acc_idle();
      acc_drive(10'd5, lane_vec(0, -32'sd3), 1'b0);
      acc_idle();
      rdy_pat.delete();
      run_drain(6, 0, 1'b0, 100);
      n_checks++;
      if (b_addr.size() != 6) begin
         n_errors++;
         $display("FAIL clracc_beats: got %0d beats, required 6", b_addr.size());
      end
      n_checks++;
      if (b_addr.size() < 6 || b_addr[5] !== 10'd5 || b_data[5][7:0] !== 8'd7) begin
         n_errors++;
         $display("FAIL clracc_value: beat5 addr/lane0 wrong (beats=%0d), required addr 5 lane0 7",
                  b_addr.size());
      end
      n_checks++;
      if (first_lat != 4) begin
         n_errors++;
         $display("FAIL drain_latency: first valid after %0d cycles, required 4", first_lat);
      end
      n_checks++;
      if (done_cnt != 1) begin
         n_errors++;
         $display("FAIL clracc_done: %0d drain_done pulses, required 1", done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      acc_drive(10'd9, lane_vec(15, 32'd100), 1'b1);
      acc_drive(10'd9, lane_vec(15, 32'd200), 1'b0);
      acc_drive(10'd9, lane_vec(15, 32'd300), 1'b0);
      acc_idle();
      rdy_pat.delete();
      run_drain(10, 4, 1'b0, 100);
      n_checks++;
      if (b_addr.size() < 10 || b_addr[9] !== 10'd9 || b_data[9][127:120] !== 8'd38) begin
         n_errors++;
         $display("FAIL b2b_value: beats=%0d lane15=%0d, required addr 9 lane15 38",
                  b_addr.size(), (b_addr.size() >= 10) ? b_data[9][127:120] : 8'd0);
      end
      n_checks++;
      if (b_addr.size() < 10 || b_data[9][7:0] !== 8'd0) begin
         n_errors++;
         $display("FAIL b2b_lane0: lane0 not 0 at addr 9, required 0");
      end
   endtask

   task automatic test_backpressure();
      for (int a = 0; a < 4; a++) begin
         acc_drive(a[9:0], lane_vec(0, 32'(11 * (a + 1))), 1'b1);
         acc_idle();
      end
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      run_drain(4, 0, 1'b0, 100);
      rdy_pat.delete();
      n_checks++;
      if (b_addr.size() != 4) begin
         n_errors++;
         $display("FAIL bp_beats: got %0d beats, required 4", b_addr.size());
      end
      for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
         n_checks++;
         if (b_addr[i] !== 10'(i) || b_data[i][7:0] !== 8'(11 * (i + 1))) begin
            n_errors++;
            $display("FAIL bp_beat%0d: addr=%0d lane0=%0d, required addr %0d lane0 %0d",
                     i, b_addr[i], b_data[i][7:0], i, 11 * (i + 1));
         end
      end
      n_checks++;
      if (unstable_cnt != 0) begin
         n_errors++;
         $display("FAIL bp_stable: %0d stall cycles changed output, required 0", unstable_cnt);
      end
      n_checks++;
      if (done_cnt != 1 || beats_at_done != 4) begin
         n_errors++;
         $display("FAIL bp_done: pulses=%0d beats_at_done=%0d, required 1 and 4", done_cnt, beats_at_done);
      end
   endtask

   task automatic test_requant_edges();
      logic [31:0] rq_v   [5] = '{-32'sd5, -32'sd5, 32'd100000, -32'sd100000, 32'h7FFF_FFFF};
      int          rq_sh  [5] = '{0, 1, 2, 2, 31};
      bit          rq_relu[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [7:0]  rq_exp [5] = '{8'h00, 8'hFE, 8'h7F, 8'h80, 8'h01};
      for (int t = 0; t < 5; t++) begin
         acc_drive(10'd0, {16{rq_v[t]}}, 1'b1);
         acc_idle();
         run_drain(1, rq_sh[t], rq_relu[t], 60);
         n_checks++;
         if (b_addr.size() != 1 || b_data[0][7:0] !== rq_exp[t] || b_data[0][127:120] !== rq_exp[t]) begin
            n_errors++;
            $display("FAIL requant_%0d: beats=%0d lane0=%h lane15=%h, required %h",
                     t, b_addr.size(), (b_addr.size() > 0) ? b_data[0][7:0] : 8'h0,
                     (b_addr.size() > 0) ? b_data[0][127:120] : 8'h0, rq_exp[t]);
         end
      end
   endtask

   task automatic test_overlap_zero();
      int hs, dn, w;
      @(negedge clk);
      drain_start = 1'b1;
      drain_count = 11'd0;
      @(negedge clk);
      drain_start = 1'b0;
      n_checks++;
      if (drain_done !== 1'b1 || ob.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL zero_count: done=%b valid=%b, required 1/0", drain_done, ob.out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (drain_done !== 1'b0 || ob.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL zero_count_pulse: done=%b valid=%b, required 0/0", drain_done, ob.out_valid);
      end

      ob.out_ready = 1'b0;
      drain_start  = 1'b1;
      drain_count  = 11'd8;
      @(negedge clk);
      drain_start = 1'b0;
      w = 0;
      while (!ob.out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      acc_drive(10'd100, '0, 1'b0);
      acc_idle();
      n_checks++;
      if (err_overlap !== 1'b1) begin
         n_errors++;
         $display("FAIL overlap_set: err_overlap=%b, required 1", err_overlap);
      end
      hs = 0; dn = 0;
      for (int k = 0; k < 80; k++) begin
         ob.out_ready = 1'b1;
         if (drain_done) dn++;
         if (ob.out_valid) hs++;
         @(negedge clk);
      end
      n_checks++;
      if (hs != 8 || dn != 1) begin
         n_errors++;
         $display("FAIL overlap_drain: beats=%0d done=%0d, required 8 and 1", hs, dn);
      end
      n_checks++;
      if (err_overlap !== 1'b1) begin
         n_errors++;
         $display("FAIL overlap_sticky: err_overlap=%b, required 1", err_overlap);
      end
   endtask

   task automatic test_reset_mid_drain();
      int hs, bad;
      ob.out_ready = 1'b1;
      @(negedge clk);
      drain_start = 1'b1;
      drain_count = 11'd8;
      shift       = 5'd0;
      relu_en     = 1'b0;
      hs = 0;
      for (int k = 0; k < 50 && hs < 2; k++) begin
         @(negedge clk);
         drain_start = 1'b0;
         if (ob.out_valid) hs++;
      end
      n_checks++;
      if (hs != 2) begin
         n_errors++;
         $display("FAIL midrst_beats: saw %0d beats before reset, required 2", hs);
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ob.out_valid !== 1'b0 || busy !== 1'b0 || drain_done !== 1'b0 || err_overlap !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_flags: valid=%b busy=%b done=%b err=%b, required all 0",
                  ob.out_valid, busy, drain_done, err_overlap);
      end
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (ob.out_valid || drain_done) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL midrst_quiet: %0d cycles with valid/done after abort, required 0", bad);
      end
      rdy_pat.delete();
      run_drain(3, 0, 1'b0, 60);
      n_checks++;
      if (b_addr.size() != 3 || b_addr[0] !== 10'd0 || b_addr[1] !== 10'd1 || b_addr[2] !== 10'd2
          || done_cnt != 1) begin
         n_errors++;
         $display("FAIL midrst_redrain: beats=%0d done=%0d, required 3 beats at 0,1,2 and 1 done",
                  b_addr.size(), done_cnt);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      acc_enable   = 1'b0;
      acc_clear    = 1'b0;
      acc_addr     = '0;
      pe_acc_in    = '0;
      drain_start  = 1'b0;
      drain_count  = '0;
      shift        = '0;
      relu_en      = 1'b0;
      ob.out_ready = 1'b1;
      test_reset();
      test_clear_accumulate();
      test_back_to_back();
      test_backpressure();
      test_requant_edges();
      test_overlap_zero();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
